tmds_encoder_hdmi: RTL and testbench

Per-lane TMDS encoder for HDMI output. Generalises the DVI lane encoder with explicit period modes: control, video, video guard band, data island (TERC4) and data island guard band. Adds a lane-index parameter for guard-band selection and a configurable output pipeline depth. Three instances (CHANNEL 0/1/2) sit between the video timing/packet scheduler and the 10:1 serialisers.

---
 rtl/tmds_pkg.sv | 58 +++++
 rtl/tmds_qm_stage.sv | 33 +++
 rtl/tmds_encoder_hdmi.sv | 129 ++++++++++++
 tb/tb_tmds_encoder_hdmi.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period modes, fixed control/guard symbols and the TERC4 lookup.
// The TERC4 lookup is only present when TMDS_ENC_TERC4_EN is defined.
package tmds_pkg;

  typedef enum logic [2:0] {
    ModeCtrl   = 3'd0,
    ModeVideo  = 3'd1,
    ModeVGuard = 3'd2,
    ModeIsland = 3'd3,
    ModeIGuard = 3'd4
  } tmds_mode_e;

  localparam logic [9:0] CtrlWord00 = 10'b1101010100;
  localparam logic [9:0] CtrlWord01 = 10'b0010101011;
  localparam logic [9:0] CtrlWord10 = 10'b0101010100;
  localparam logic [9:0] CtrlWord11 = 10'b1010101011;

  // Guard-band symbols: A on lanes 0/2 for video, B on lane 1 and on island lanes 1/2.
  localparam logic [9:0] GuardWordA = 10'b1011001100;
  localparam logic [9:0] GuardWordB = 10'b0100110011;

  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    logic [9:0] w;
    case (c)
      2'b00:   w = CtrlWord00;
      2'b01:   w = CtrlWord01;
      2'b10:   w = CtrlWord10;
      default: w = CtrlWord11;
    endcase
    return w;
  endfunction

`ifdef TMDS_ENC_TERC4_EN
  function automatic logic [9:0] terc4_word(input logic [3:0] d);
    logic [9:0] w;
    case (d)
      4'h0:    w = 10'b1010011100;
      4'h1:    w = 10'b1001100011;
      4'h2:    w = 10'b1011100100;
      4'h3:    w = 10'b1011100010;
      4'h4:    w = 10'b0101110001;
      4'h5:    w = 10'b0100011110;
      4'h6:    w = 10'b0110001110;
      4'h7:    w = 10'b0100111100;
      4'h8:    w = 10'b1011001100;
      4'h9:    w = 10'b0100111001;
      4'hA:    w = 10'b0110011100;
      4'hB:    w = 10'b1011000110;
      4'hC:    w = 10'b1010001110;
      4'hD:    w = 10'b1001110001;
      4'hE:    w = 10'b0101100011;
      default: w = 10'b1011000011;
    endcase
    return w;
  endfunction
`endif

endpackage

// File: rtl/tmds_qm_stage.sv
// Combinational 8b->9b transition minimisation with the resulting word balance
// (2*ones(qm[7:0]) - 8).
module tmds_qm_stage (
  input  logic [7:0]        data_i,
  output logic [8:0]        qm_o,
  output logic signed [4:0] balance_o
);

  logic [3:0] ones_data;
  logic [3:0] ones_qm;
  logic       use_xnor;
  logic [8:0] q;

  always_comb begin
    ones_data = '0;
    for (int i = 0; i < 8; i++) ones_data = ones_data + 4'(data_i[i]);
    use_xnor = (ones_data > 4'd4) || ((ones_data == 4'd4) && !data_i[0]);

    q    = '0;
    q[0] = data_i[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ data_i[i]) : (q[i-1] ^ data_i[i]);
    end
    q[8] = ~use_xnor;

    ones_qm = '0;
    for (int i = 0; i < 8; i++) ones_qm = ones_qm + 4'(q[i]);
  end

  assign qm_o      = q;
  assign balance_o = $signed({ones_qm, 1'b0} - 5'd8);

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// Per-lane HDMI TMDS encoder: control, video (DC balanced), guard bands and TERC4 islands.
// Define TMDS_ENC_TERC4_EN for the data-island path; otherwise ISLAND/IGUARD encode as control.
module tmds_encoder_hdmi
  import tmds_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned PIPE    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_mode,
  input  logic [7:0]        i_data,
  input  logic [1:0]        i_ctrl,
  input  logic [3:0]        i_aux,
  output logic [9:0]        o_tmds,
  output logic signed [4:0] o_bias
);

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("tmds_encoder_hdmi: PIPE must be 1 or 2");
  end

  logic [8:0]        qm;
  logic signed [4:0] balance;
  logic              is_video;
  logic [9:0]        fixed_word;

  tmds_qm_stage u_qm (
    .data_i   (i_data),
    .qm_o     (qm),
    .balance_o(balance)
  );

  assign is_video = (i_mode == ModeVideo);

  // Modes 5..7 (and CTRL itself) fall through to the control word.
  always_comb begin
    fixed_word = ctrl_word(i_ctrl);
    case (i_mode)
      ModeVGuard: fixed_word = (CHANNEL == 1) ? GuardWordB : GuardWordA;
`ifdef TMDS_ENC_TERC4_EN
      ModeIsland: fixed_word = terc4_word(i_aux);
      ModeIGuard: fixed_word = (CHANNEL == 0) ? terc4_word({2'b11, i_ctrl}) : GuardWordB;
`endif
      default: ;
    endcase
  end

`ifndef TMDS_ENC_TERC4_EN
  logic unused_aux;
  assign unused_aux = ^i_aux;
`endif

  logic [8:0]        s_qm;
  logic signed [4:0] s_bal;
  logic              s_video;
  logic [9:0]        s_fixed;

  if (PIPE == 2) begin : g_stage1
    logic [8:0]        qm_q;
    logic signed [4:0] bal_q;
    logic              video_q;
    logic [9:0]        fixed_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        qm_q    <= '0;
        bal_q   <= '0;
        video_q <= 1'b0;
        fixed_q <= CtrlWord00;
      end else begin
        qm_q    <= qm;
        bal_q   <= balance;
        video_q <= is_video;
        fixed_q <= fixed_word;
      end
    end

    assign s_qm    = qm_q;
    assign s_bal   = bal_q;
    assign s_video = video_q;
    assign s_fixed = fixed_q;
  end else begin : g_direct
    assign s_qm    = qm;
    assign s_bal   = balance;
    assign s_video = is_video;
    assign s_fixed = fixed_word;
  end

  logic [9:0]        tmds_d, tmds_q;
  logic signed [4:0] bias_d, bias_q;

  // DC balancing; any non-video symbol restarts the running disparity at zero.
  always_comb begin
    tmds_d = s_fixed;
    bias_d = '0;
    if (s_video) begin
      if (bias_q == '0 || s_bal == '0) begin
        if (!s_qm[8]) begin
          tmds_d = {2'b10, ~s_qm[7:0]};
          bias_d = bias_q - s_bal;
        end else begin
          tmds_d = {2'b01, s_qm[7:0]};
          bias_d = bias_q + s_bal;
        end
      end else if (bias_q[4] == s_bal[4]) begin
        tmds_d = {1'b1, s_qm[8], ~s_qm[7:0]};
        bias_d = bias_q + {3'b000, s_qm[8], 1'b0} - s_bal;
      end else begin
        tmds_d = {1'b0, s_qm[8], s_qm[7:0]};
        bias_d = bias_q - {3'b000, ~s_qm[8], 1'b0} + s_bal;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmds_q <= CtrlWord00;
      bias_q <= '0;
    end else begin
      tmds_q <= tmds_d;
      bias_q <= bias_d;
    end
  end

  assign o_tmds = tmds_q;
  assign o_bias = bias_q;

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// Randomised self-checking bench for tmds_encoder_hdmi on three lanes (PIPE 1, 2, 1)
// against a behavioural reference; honours TMDS_ENC_TERC4_EN.
module tb_tmds_encoder_hdmi;

  localparam int Pipe [3] = '{1, 2, 1};
  localparam logic [9:0] RstWord = 10'b1101010100;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [7:0] data = 8'h00;
  logic [1:0] ctrl = 2'b00;
  logic [3:0] aux  = 4'h0;

  logic [9:0]        tmds [3];
  logic signed [4:0] bias [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] terc_lit [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  always #5 clk = ~clk;

  tmds_encoder_hdmi #(.CHANNEL(0), .PIPE(1)) u_ch0 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl), .i_aux(aux),
    .o_tmds(tmds[0]), .o_bias(bias[0])
  );
  tmds_encoder_hdmi #(.CHANNEL(1), .PIPE(2)) u_ch1 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl), .i_aux(aux),
    .o_tmds(tmds[1]), .o_bias(bias[1])
  );
  tmds_encoder_hdmi #(.CHANNEL(2), .PIPE(1)) u_ch2 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_data(data), .i_ctrl(ctrl), .i_aux(aux),
    .o_tmds(tmds[2]), .o_bias(bias[2])
  );

  task automatic chk_w(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string nm, input logic signed [4:0] act, input int exp);
    n_cmp++;
    if (act !== 5'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] m_ctrl(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] m_fixed(input int ch, input logic [2:0] m,
                                         input logic [1:0] c, input logic [3:0] a);
    logic [9:0] w;
    w = m_ctrl(c);
    if (m == 3'd2) w = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
`ifdef TMDS_ENC_TERC4_EN
    if (m == 3'd3) w = terc_lit[a];
    if (m == 3'd4) w = (ch == 0) ? terc_lit[{2'b11, c}] : 10'b0100110011;
`endif
    return w;
  endfunction

  // Word choice from the minimisation/balancing rules; the new bias is simply the
  // running ones-minus-zeros count of the emitted 10-bit symbol.
  task automatic m_video(input logic [7:0] d, input int b_in, output int b_out,
                         output logic [9:0] w);
    int n1, bal;
    logic xn;
    logic [8:0] q;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    bal = 2 * $countones(q[7:0]) - 8;
    if (b_in == 0 || bal == 0) w = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
    else if ((b_in > 0) == (bal > 0)) w = {1'b1, q[8], ~q[7:0]};
    else w = {1'b0, q[8], q[7:0]};
    b_out = b_in + 2 * $countones(w) - 10;
  endtask

  int         m_bias;
  logic [9:0] vw;
  logic [9:0] h_w [3][2];
  int         h_b [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_bias = 0;
      for (int c = 0; c < 3; c++) for (int k = 0; k < 2; k++) h_w[c][k] = RstWord;
      h_b[0] = 0;
      h_b[1] = 0;
    end else begin
      h_b[1] = h_b[0];
      for (int c = 0; c < 3; c++) h_w[c][1] = h_w[c][0];
      if (mode == 3'd1) begin
        m_video(data, m_bias, m_bias, vw);
        for (int c = 0; c < 3; c++) h_w[c][0] = vw;
      end else begin
        m_bias = 0;
        for (int c = 0; c < 3; c++) h_w[c][0] = m_fixed(c, mode, ctrl, aux);
      end
      h_b[0] = m_bias;
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_w($sformatf("ch%0d_tmds", c), tmds[c], h_w[c][Pipe[c]-1]);
      chk_b($sformatf("ch%0d_bias", c), bias[c], h_b[Pipe[c]-1]);
      n_cmp++;
      if (bias[c] > 5'sd10 || bias[c] < -5'sd10) begin
        n_bad++;
        $display("FAIL ch%0d_disparity_bound: got %0d expected |bias|<=10", c, bias[c]);
      end
    end
  end

  task automatic step(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c,
                      input logic [3:0] a);
    @(negedge clk);
    mode = m;
    data = d;
    ctrl = c;
    aux  = a;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] exp_isl, exp_ig0, exp_igx;
    int r;

    repeat (3) @(posedge clk);
    #2;
    for (int c = 0; c < 3; c++) begin
      chk_w("reset_tmds", tmds[c], 10'b1101010100);
      chk_b("reset_bias", bias[c], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    step(3'd0, 8'h00, 2'b00, 4'h0);
    step(3'd1, 8'h00, 2'b00, 4'h0);
    chk_w("video00_first", tmds[0], 10'b0100000000);
    chk_b("video00_first_bias", bias[0], -8);
    step(3'd1, 8'h00, 2'b00, 4'h0);
    chk_w("video00_second", tmds[0], 10'b1111111111);
    chk_b("video00_second_bias", bias[0], 2);
    step(3'd0, 8'h00, 2'b01, 4'h0);
    chk_w("ctrl01", tmds[0], 10'b0010101011);
    chk_b("ctrl01_bias", bias[0], 0);
    step(3'd1, 8'h00, 2'b00, 4'h0);
    chk_w("video_after_ctrl", tmds[0], 10'b0100000000);
    chk_b("video_after_ctrl_bias", bias[0], -8);

    step(3'd2, 8'h00, 2'b00, 4'h0);
    step(3'd2, 8'h00, 2'b00, 4'h0);
    chk_w("vguard_ch0", tmds[0], 10'b1011001100);
    chk_w("vguard_ch1", tmds[1], 10'b0100110011);
    chk_w("vguard_ch2", tmds[2], 10'b1011001100);

    for (int i = 0; i < 16; i++) begin
`ifdef TMDS_ENC_TERC4_EN
      exp_isl = terc_lit[i];
`else
      exp_isl = 10'b1010101011;
`endif
      step(3'd3, 8'h00, 2'b11, 4'(i));
      chk_w($sformatf("island_%0h", i), tmds[0], exp_isl);
    end

`ifdef TMDS_ENC_TERC4_EN
    exp_ig0 = 10'b0101100011;
    exp_igx = 10'b0100110011;
`else
    exp_ig0 = 10'b0101010100;
    exp_igx = 10'b0101010100;
`endif
    step(3'd4, 8'h00, 2'b10, 4'h0);
    step(3'd4, 8'h00, 2'b10, 4'h0);
    chk_w("iguard_ch0", tmds[0], exp_ig0);
    chk_w("iguard_ch1", tmds[1], exp_igx);
    chk_w("iguard_ch2", tmds[2], exp_igx);

    // Reset dropped in the middle of a video symbol, no clock edge involved.
    for (int i = 0; i < 3; i++) step(3'd1, 8'(8'hA5 + 8'(i)), 2'b00, 4'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_w("midreset_tmds", tmds[c], 10'b1101010100);
      chk_b("midreset_bias", bias[c], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      r    = $urandom_range(0, 9);
      mode = (r < 7) ? 3'd1 : 3'($urandom_range(0, 7));
      data = 8'($urandom);
      ctrl = 2'($urandom);
      aux  = 4'($urandom);
    end

    @(negedge clk);
    mode = 3'd0;
    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
